// File: rtl/sync_edge_pkg.sv
// Shared definitions for the synchronising edge/debounce front end:
// edge-mode encodings and the debounce counter width helper.
package sync_edge_pkg;

    localparam logic [1:0] EDGE_NONE = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_debounce_ch.sv
// One channel: metastability synchroniser, stable-count debouncer and
// registered rise/fall pulses. rise_set/fall_set expose the next pulse values.
module sync_debounce_ch
    import sync_edge_pkg::*;
#(
    parameter int   SYNC_STAGES  = 2,
    parameter int   DEBOUNCE_CNT = 1,
    parameter logic RESET_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rise_set,
    output logic fall_set
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   level_nxt;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    // Plain shift chain; nothing may sit between the stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    // Debounce: any return to the stable level before terminal count drops the count.
    always_comb begin
        cnt_nxt   = cnt;
        level_nxt = level;
        rise_set  = 1'b0;
        fall_set  = 1'b0;
        if (s == level) begin
            cnt_nxt = {CNT_W{1'b0}};
        end else if (cnt == CNT_TERM) begin
            cnt_nxt   = {CNT_W{1'b0}};
            level_nxt = s;
            rise_set  = s;
            fall_set  = ~s;
        end else begin
            cnt_nxt = cnt + CNT_ONE;
        end
    end

    // Level, counter and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= {CNT_W{1'b0}};
            level <= RESET_LEVEL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            level <= level_nxt;
            rise  <= rise_set;
            fall  <= fall_set;
        end
    end

endmodule

// File: rtl/sync_edge_debounce.sv
// Multi-channel debounced edge detector with per-channel event selection,
// sticky pending flags and a summary interrupt.
module sync_edge_debounce
    import sync_edge_pkg::*;
#(
    parameter int   WIDTH        = 4,
    parameter int   SYNC_STAGES  = 2,
    parameter int   DEBOUNCE_CNT = 1,
    parameter logic RESET_LEVEL  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic [2*WIDTH-1:0]   edge_sel,
    input  logic [WIDTH-1:0]     clr,
    output logic [WIDTH-1:0]     level,
    output logic [WIDTH-1:0]     rise,
    output logic [WIDTH-1:0]     fall,
    output logic [WIDTH-1:0]     edge_event,
    output logic [WIDTH-1:0]     pend,
    output logic                 irq
);

    logic [WIDTH-1:0] rise_set;
    logic [WIDTH-1:0] fall_set;
    logic [WIDTH-1:0] event_nxt;
    logic [WIDTH-1:0] pend_nxt;

    for (genvar i = 0; i < WIDTH; i++) begin : gen_ch
        sync_debounce_ch #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEBOUNCE_CNT (DEBOUNCE_CNT),
            .RESET_LEVEL  (RESET_LEVEL)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .din      (din[i]),
            .level    (level[i]),
            .rise     (rise[i]),
            .fall     (fall[i]),
            .rise_set (rise_set[i]),
            .fall_set (fall_set[i])
        );
    end

    // edge_sel is applied to the pulse being registered, so a later change never touches it.
    always_comb begin
        event_nxt = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            case (edge_sel[2*i +: 2])
                EDGE_NONE: event_nxt[i] = 1'b0;
                EDGE_RISE: event_nxt[i] = rise_set[i];
                EDGE_FALL: event_nxt[i] = fall_set[i];
                EDGE_BOTH: event_nxt[i] = rise_set[i] | fall_set[i];
                default:   event_nxt[i] = 1'b0;
            endcase
        end
        pend_nxt = (pend & ~clr) | event_nxt;
    end

    // Event, pending and interrupt registers; irq tracks the next pend value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_event <= {WIDTH{1'b0}};
            pend       <= {WIDTH{1'b0}};
            irq        <= 1'b0;
        end else begin
            edge_event <= event_nxt;
            pend       <= pend_nxt;
            irq        <= |pend_nxt;
        end
    end

endmodule
